// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator for decode: classifies the immediate format, extends it to XLEN
// and presents it through a registered output stage with an optional one-entry skid buffer.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            ill;
  } res_t;

  res_t             dec;
  res_t             out_q, out_d;
  res_t             skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc;

  // Format classification
  always_comb begin
    dec.fmt = FMT_NONE;
    dec.ill = 1'b0;
    unique case (instruction[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: dec.fmt = FMT_I;
      7'b0100011:                         dec.fmt = FMT_S;
      7'b1100011:                         dec.fmt = FMT_B;
      7'b0110111, 7'b0010111:             dec.fmt = FMT_U;
      7'b1101111:                         dec.fmt = FMT_J;
      7'b1110011:                         dec.fmt = instruction[14] ? FMT_Z : FMT_I;
      7'b0110011, 7'b0111011, 7'b0001111: dec.fmt = FMT_NONE;
      default:                            dec.ill = 1'b1;
    endcase
  end

  // Immediate extraction and extension; U fills the upper half from bit 31 when XLEN=64
  always_comb begin
    dec.imm = '0;
    unique case (dec.fmt)
      FMT_I: dec.imm = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
      FMT_S: dec.imm = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B: dec.imm = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
      FMT_U: begin
        dec.imm        = {XLEN{instruction[31]}};
        dec.imm[31:0]  = {instruction[31:12], 12'b0};
      end
      FMT_J: dec.imm = {{(XLEN-21){instruction[31]}}, instruction[31], instruction[19:12],
                        instruction[20], instruction[30:21], 1'b0};
      FMT_Z: dec.imm[4:0] = instruction[19:15];
      default: dec.imm = '0;
    endcase
  end

  // Ready is held low while reset is asserted so nothing is accepted or counted then
  always_comb begin
    if (SKID != 0) in_ready = !reset && !skid_valid_q;
    else           in_ready = !reset && (!out_valid_q || out_ready);
  end

  assign acc = in_valid && in_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;

    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = acc;
        if (acc) skid_d = dec;
      end else if (acc) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (acc && (SKID != 0)) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end

    if (acc && dec.ill && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.ill;
  assign illegal_cnt = cnt_q;

endmodule
